vfu_mask_router: RTL

- Generalised successor to the lane's two-unit mask glue. Sits between the lane's NrFUs functional units and the mask unit.
- Mask direction: the mask unit sends beats tagged with a destination FU index. Each beat is buffered in that FU's own FIFO, so no beat is broadcast to every FU.
- Operand direction: the operand stream from the FU chosen by the mask unit is registered through a one-entry output stage, and the stage also outputs that FU's tag.
- Also aggregates the mask-expected status sent to the edge spill register, and supports a synchronous flush.

---
 rtl/vfu_mask_router_if.sv | 52 +++++
 rtl/vfu_mask_router.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/vfu_mask_router_if.sv
// Bus bundle between the lane's functional units, the mask unit and vfu_mask_router.
// slave  : the router's view (mask beats and operands in, per-FU heads and the registered operand out).
// master : the surrounding lane's view of the same signals.
interface vfu_mask_router_if #(
  parameter int unsigned NrFUs     = 2,
  parameter int unsigned DataWidth = 64
);
  localparam int unsigned MaskW  = DataWidth / 8;
  localparam int unsigned FuIdxW = (NrFUs > 1) ? $clog2(NrFUs) : 1;

  // Mask unit -> FUs
  logic [MaskW-1:0]        mask_i;
  logic [FuIdxW-1:0]       mask_fu_i;
  logic                    mask_valid_i;
  logic                    mask_ready_o;
  logic [NrFUs*MaskW-1:0]  fu_mask_o;
  logic [NrFUs-1:0]        fu_mask_valid_o;
  logic [NrFUs-1:0]        fu_mask_ready_i;

  // FUs -> mask unit
  logic [NrFUs*DataWidth-1:0] fu_mask_operand_i;
  logic [NrFUs-1:0]           fu_mask_operand_valid_i;
  logic [NrFUs-1:0]           fu_mask_operand_ready_o;
  logic [FuIdxW-1:0]          mask_operand_fu_i;
  logic [DataWidth-1:0]       mask_operand_o;
  logic [FuIdxW-1:0]          mask_operand_fu_o;
  logic                       mask_operand_valid_o;
  logic                       mask_operand_ready_i;

  // Status
  logic [NrFUs-1:0]        fu_mask_expected_i;
  logic                    mask_expected_o;
  logic                    illegal_fu_o;

  modport slave (
    input  mask_i, mask_fu_i, mask_valid_i, fu_mask_ready_i,
           fu_mask_operand_i, fu_mask_operand_valid_i, mask_operand_fu_i,
           mask_operand_ready_i, fu_mask_expected_i,
    output mask_ready_o, fu_mask_o, fu_mask_valid_o, fu_mask_operand_ready_o,
           mask_operand_o, mask_operand_fu_o, mask_operand_valid_o,
           mask_expected_o, illegal_fu_o
  );

  modport master (
    output mask_i, mask_fu_i, mask_valid_i, fu_mask_ready_i,
           fu_mask_operand_i, fu_mask_operand_valid_i, mask_operand_fu_i,
           mask_operand_ready_i, fu_mask_expected_i,
    input  mask_ready_o, fu_mask_o, fu_mask_valid_o, fu_mask_operand_ready_o,
           mask_operand_o, mask_operand_fu_o, mask_operand_valid_o,
           mask_expected_o, illegal_fu_o
  );
endinterface

// File: rtl/vfu_mask_router.sv
// Routes mask beats from the mask unit into one FIFO per functional unit, and
// registers the operand of the FU selected by the mask unit through a one-entry stage.
// Ports:
//   clk_i   : clock, rising edge
//   rst_i   : asynchronous active-high reset
//   flush_i : synchronous clear of all FIFOs and the operand stage
//   bus     : vfu_mask_router_if.slave (mask beats, per-FU heads, operand stream, status)
module vfu_mask_router #(
  parameter int unsigned NrFUs          = 2,
  parameter int unsigned MaskQueueDepth = 2,
  parameter int unsigned DataWidth      = 64
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 flush_i,
  vfu_mask_router_if.slave     bus
);
  localparam int unsigned MaskW  = DataWidth / 8;
  localparam int unsigned FuIdxW = (NrFUs > 1) ? $clog2(NrFUs) : 1;
  localparam int unsigned PtrW   = $clog2(MaskQueueDepth);
  localparam int unsigned CntW   = PtrW + 1;

  typedef logic [MaskW-1:0] mask_beat_t;

  mask_beat_t      mem_q    [NrFUs][MaskQueueDepth];
  mask_beat_t      mem_d    [NrFUs][MaskQueueDepth];
  logic [PtrW-1:0] wr_ptr_q [NrFUs];
  logic [PtrW-1:0] wr_ptr_d [NrFUs];
  logic [PtrW-1:0] rd_ptr_q [NrFUs];
  logic [PtrW-1:0] rd_ptr_d [NrFUs];
  logic [CntW-1:0] cnt_q    [NrFUs];
  logic [CntW-1:0] cnt_d    [NrFUs];

  logic [NrFUs-1:0] full, not_empty, push, pop;
  logic             mask_legal, dest_full, mask_ready, mask_accept;
  logic             illegal_q, illegal_d;

  logic [DataWidth-1:0] op_data_q, op_data_d;
  logic [FuIdxW-1:0]    op_fu_q, op_fu_d;
  logic                 op_valid_q, op_valid_d;
  logic                 op_load, op_sel_legal, op_sel_valid, op_hs;
  logic [DataWidth-1:0] op_sel_data;

  // FIFO status and ingress decode; ready deliberately ignores a same-cycle pop
  always_comb begin
    full        = '0;
    not_empty   = '0;
    dest_full   = 1'b0;
    push        = '0;
    pop         = '0;
    mask_legal  = 32'(bus.mask_fu_i) < NrFUs;
    for (int unsigned f = 0; f < NrFUs; f++) begin
      full[f]      = cnt_q[f] == CntW'(MaskQueueDepth);
      not_empty[f] = cnt_q[f] != CntW'(0);
      if (FuIdxW'(f) == bus.mask_fu_i) dest_full = full[f];
    end
    mask_ready  = !flush_i && (!mask_legal || !dest_full);
    mask_accept = bus.mask_valid_i && mask_ready;
    for (int unsigned f = 0; f < NrFUs; f++) begin
      push[f] = mask_accept && mask_legal && (FuIdxW'(f) == bus.mask_fu_i);
      pop[f]  = not_empty[f] && bus.fu_mask_ready_i[f];
    end
    // Out-of-range beats are swallowed and reported one cycle later
    illegal_d = mask_accept && !mask_legal;
  end

  // Per-FU FIFO next state: pointers wrap naturally since depth is a power of two
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    for (int unsigned f = 0; f < NrFUs; f++) begin
      if (flush_i) begin
        wr_ptr_d[f] = '0;
        rd_ptr_d[f] = '0;
        cnt_d[f]    = '0;
      end else begin
        if (push[f]) begin
          mem_d[f][wr_ptr_q[f]] = bus.mask_i;
          wr_ptr_d[f]           = wr_ptr_q[f] + PtrW'(1);
        end
        if (pop[f]) rd_ptr_d[f] = rd_ptr_q[f] + PtrW'(1);
        case ({push[f], pop[f]})
          2'b10:   cnt_d[f] = cnt_q[f] + CntW'(1);
          2'b01:   cnt_d[f] = cnt_q[f] - CntW'(1);
          default: cnt_d[f] = cnt_q[f];
        endcase
      end
    end
  end

  // Operand stage: select the FU the mask unit waits on and load when the stage can accept
  always_comb begin
    op_data_d    = op_data_q;
    op_fu_d      = op_fu_q;
    op_valid_d   = op_valid_q;
    op_sel_valid = 1'b0;
    op_sel_data  = '0;
    op_load      = op_valid_q ? bus.mask_operand_ready_i : 1'b1;
    op_sel_legal = 32'(bus.mask_operand_fu_i) < NrFUs;
    for (int unsigned f = 0; f < NrFUs; f++) begin
      if (FuIdxW'(f) == bus.mask_operand_fu_i) begin
        op_sel_valid = bus.fu_mask_operand_valid_i[f];
        op_sel_data  = bus.fu_mask_operand_i[f*DataWidth +: DataWidth];
      end
    end
    // Held low while in reset so no FU sees a consume that the stage will not keep
    op_hs = op_load && op_sel_valid && op_sel_legal && !flush_i && !rst_i;
    if (flush_i) begin
      op_valid_d = 1'b0;
    end else if (op_hs) begin
      op_data_d  = op_sel_data;
      op_fu_d    = bus.mask_operand_fu_i;
      op_valid_d = 1'b1;
    end else if (op_valid_q && bus.mask_operand_ready_i) begin
      op_valid_d = 1'b0;
    end
  end

  // Output drive
  always_comb begin
    bus.fu_mask_o               = '0;
    bus.fu_mask_operand_ready_o = '0;
    for (int unsigned f = 0; f < NrFUs; f++) begin
      bus.fu_mask_o[f*MaskW +: MaskW] = mem_q[f][rd_ptr_q[f]];
      bus.fu_mask_operand_ready_o[f]  = op_hs && (FuIdxW'(f) == bus.mask_operand_fu_i);
    end
    bus.fu_mask_valid_o      = not_empty;
    bus.mask_ready_o         = mask_ready;
    bus.mask_operand_o       = op_data_q;
    bus.mask_operand_fu_o    = op_fu_q;
    bus.mask_operand_valid_o = op_valid_q;
    bus.illegal_fu_o         = illegal_q;
    // Pending beats still count as expected mask traffic for the spill register
    bus.mask_expected_o      = (|bus.fu_mask_expected_i) || (|not_empty);
  end

  // State registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned f = 0; f < NrFUs; f++) begin
        for (int unsigned e = 0; e < MaskQueueDepth; e++) mem_q[f][e] <= '0;
        wr_ptr_q[f] <= '0;
        rd_ptr_q[f] <= '0;
        cnt_q[f]    <= '0;
      end
      illegal_q  <= 1'b0;
      op_data_q  <= '0;
      op_fu_q    <= '0;
      op_valid_q <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      illegal_q  <= illegal_d;
      op_data_q  <= op_data_d;
      op_fu_q    <= op_fu_d;
      op_valid_q <= op_valid_d;
    end
  end
endmodule
